prefetch_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RV32I/RV64I core.
- Replaces the single IR-plus-PC fetch of the multicycle dataflow with a DEPTH-entry prefetch queue of {pc, instruction} pairs.
- Talks to instruction memory over a request/acknowledge handshake and delivers to decode over valid/ready.
- Handles pipeline redirects (branch, jump, trap, xRET), including a redirect while a memory request is still in flight.

---
 rtl/prefetch_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_prefetch_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fetch_unit.sv
// prefetch_fetch_unit
//
// Instruction-fetch front end with a DEPTH-entry prefetch queue of {pc, instruction} pairs.
// Requests go to instruction memory over a rd_en/ack handshake, with at most one request
// outstanding at a time. Queue entries go to decode over valid/ready. A redirect flushes the
// queue and restarts fetch at a new PC. When a redirect arrives while a request is still
// waiting for its ack, that request is held until it completes and its data is then dropped.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   fetch_en     in   permits new memory requests
//   mem_rd_en    out  instruction read request, held until mem_ack
//   mem_addr     out  request address, stable while mem_rd_en=1
//   mem_ack      in   request completes this cycle; mem_rd_data is valid
//   mem_rd_data  in   instruction word
//   redirect     in   flush the queue and restart fetch at redirect_pc
//   redirect_pc  in   new fetch address; bits [1:0] are ignored
//   inst_valid   out  queue head valid
//   inst_ready   in   decode consumes the head when inst_valid=1
//   inst         out  head instruction
//   inst_pc      out  head PC
//   queue_count  out  current queue occupancy
module prefetch_fetch_unit #(
  parameter int unsigned          DATA_SIZE = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic                     mem_rd_en,
  output logic [DATA_SIZE-1:0]     mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rd_data,
  input  logic                     redirect,
  input  logic [DATA_SIZE-1:0]     redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst,
  output logic [DATA_SIZE-1:0]     inst_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDiscard
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [DATA_SIZE-1:0] r_fetch_pc;
  logic [DATA_SIZE-1:0] w_fetch_pc_next;
  logic [DATA_SIZE-1:0] r_stale_addr;
  logic [DATA_SIZE-1:0] w_stale_addr_next;
  logic [PtrW-1:0]      r_head;
  logic [PtrW-1:0]      r_tail;
  logic [CntW-1:0]      r_count;

  logic [DATA_SIZE-1:0] r_pc_mem   [DEPTH];
  logic [31:0]          r_inst_mem [DEPTH];

  logic                 w_push;
  logic                 w_pop;
  logic [CntW-1:0]      w_next_count;
  logic                 w_credit;
  logic [DATA_SIZE-1:0] w_redirect_pc;
  logic                 w_unused_rpc_lsb;

  assign w_unused_rpc_lsb = ^redirect_pc[1:0];
  assign w_redirect_pc    = {redirect_pc[DATA_SIZE-1:2], 2'b00};

  assign inst_valid  = (r_count != '0);
  assign inst        = r_inst_mem[r_head];
  assign inst_pc     = r_pc_mem[r_head];
  assign queue_count = r_count;

  // Memory-side outputs depend on registered state only, so there is no path from mem_ack.
  assign mem_rd_en = (r_state != StIdle);
  assign mem_addr  = (r_state == StDiscard) ? r_stale_addr : r_fetch_pc;

  assign w_push       = (r_state == StReq) & mem_ack & ~redirect;
  assign w_pop        = inst_valid & inst_ready & ~redirect;
  assign w_next_count = r_count + CntW'(w_push) - CntW'(w_pop);
  // A new request is only issued if its returning word is guaranteed a free slot.
  assign w_credit     = (w_next_count < DepthC);

  always_comb begin
    w_state_next      = r_state;
    w_fetch_pc_next   = r_fetch_pc;
    w_stale_addr_next = r_stale_addr;

    if (redirect) begin
      w_fetch_pc_next = w_redirect_pc;
    end else if (w_push) begin
      w_fetch_pc_next = r_fetch_pc + DATA_SIZE'(4);
    end

    unique case (r_state)
      StIdle: begin
        // After a redirect the queue is empty, so credit is implied.
        if (redirect) begin
          if (fetch_en) w_state_next = StReq;
        end else if (fetch_en && w_credit) begin
          w_state_next = StReq;
        end
      end
      StReq: begin
        if (redirect) begin
          if (mem_ack) begin
            w_state_next = fetch_en ? StReq : StIdle;
          end else begin
            // The memory still owns this request; keep presenting its address until it acks.
            w_stale_addr_next = r_fetch_pc;
            w_state_next      = StDiscard;
          end
        end else if (mem_ack) begin
          w_state_next = (fetch_en && w_credit) ? StReq : StIdle;
        end
      end
      StDiscard: begin
        // The stale request ends on ack even if another redirect arrives in the same cycle.
        if (mem_ack) w_state_next = fetch_en ? StReq : StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_stale_addr <= w_stale_addr_next;
      if (redirect) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_count <= w_next_count;
        if (w_pop)  r_head <= r_head + PtrW'(1);
        if (w_push) r_tail <= r_tail + PtrW'(1);
      end
    end
  end

  // Payload storage needs no reset; entries are qualified by r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_fetch_pc;
      r_inst_mem[r_tail] <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
module tb_prefetch_fetch_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // 32-bit instance, RESET_PC = 0
  logic        reset, fetch_en, mem_ack, redirect, inst_ready;
  logic [31:0] mem_rd_data, redirect_pc;
  logic        mem_rd_en, inst_valid;
  logic [31:0] mem_addr, inst, inst_pc;
  logic [2:0]  queue_count;

  // 64-bit instance, RESET_PC = 0x8000_0000
  logic        rst64, fe64, ack64, redir64, rdy64;
  logic [31:0] data64;
  logic [63:0] rpc64;
  logic        rd64, valid64;
  logic [63:0] addr64, pc64;
  logic [31:0] inst64;
  logic [2:0]  cnt64;

  localparam logic [63:0] Rp64 = 64'h0000_0000_8000_0000;

  prefetch_fetch_unit #(.DATA_SIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .queue_count(queue_count)
  );

  prefetch_fetch_unit #(.DATA_SIZE(64), .DEPTH(4), .RESET_PC(Rp64)) dut64 (
    .clock(clock), .reset(rst64), .fetch_en(fe64), .mem_rd_en(rd64),
    .mem_addr(addr64), .mem_ack(ack64), .mem_rd_data(data64), .redirect(redir64),
    .redirect_pc(rpc64), .inst_valid(valid64), .inst_ready(rdy64), .inst(inst64),
    .inst_pc(pc64), .queue_count(cnt64)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] word(input logic [63:0] a);
    return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h1234};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        fe;
    logic        ack;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e_rd, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [2:0] e_cnt, input logic fe,
                     input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
    vec_t v;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_cnt = e_cnt;
    v.fe = fe; v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    tbl.push_back(v);
  endtask

  // Checks the 32-bit instance's current outputs; the rows are checked this way too.
  task automatic chk32(input string tag, input logic e_rd, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc, input logic [2:0] e_cnt);
    check({tag, " mem_rd_en"}, 64'(mem_rd_en), 64'(e_rd));
    check({tag, " mem_addr"}, 64'(mem_addr), 64'(e_addr));
    check({tag, " inst_valid"}, 64'(inst_valid), 64'(e_valid));
    check({tag, " queue_count"}, 64'(queue_count), 64'(e_cnt));
    if (e_valid) begin
      check({tag, " inst_pc"}, 64'(inst_pc), 64'(e_pc));
      check({tag, " inst"}, 64'(inst), 64'(word(64'(e_pc))));
    end
  endtask

  task automatic drive32(input logic fe, input logic ack, input logic rdy, input logic redir,
                         input logic [31:0] rpc);
    fetch_en = fe; mem_ack = ack; inst_ready = rdy; redirect = redir; redirect_pc = rpc;
    mem_rd_data = word(64'(mem_addr));
  endtask

  initial begin
    reset = 1'b0; rst64 = 1'b0;
    drive32(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    fe64 = 1'b0; ack64 = 1'b0; redir64 = 1'b0; rdy64 = 1'b0; rpc64 = '0; data64 = '0;

    // e_rd, e_addr, e_valid, e_pc, e_cnt | fe, ack, rdy, redir, rpc
    add(0, 32'h000, 0, 32'h000, 0,  1, 0, 0, 0, 32'h0);   // fill, no pop
    add(1, 32'h000, 0, 32'h000, 0,  1, 1, 0, 0, 32'h0);
    add(1, 32'h004, 1, 32'h000, 1,  1, 1, 0, 0, 32'h0);
    add(1, 32'h008, 1, 32'h000, 2,  1, 1, 0, 0, 32'h0);
    add(1, 32'h00C, 1, 32'h000, 3,  1, 1, 0, 0, 32'h0);
    add(0, 32'h010, 1, 32'h000, 4,  1, 0, 0, 0, 32'h0);   // full: no request
    add(0, 32'h010, 1, 32'h000, 4,  1, 0, 1, 0, 32'h0);   // one pop -> one request
    add(1, 32'h010, 1, 32'h004, 3,  0, 0, 0, 0, 32'h0);   // fetch_en dropped, request held
    add(1, 32'h010, 1, 32'h004, 3,  0, 1, 0, 0, 32'h0);
    add(0, 32'h014, 1, 32'h004, 4,  0, 0, 1, 0, 32'h0);   // drain
    add(0, 32'h014, 1, 32'h008, 3,  0, 0, 1, 0, 32'h0);
    add(0, 32'h014, 1, 32'h00C, 2,  0, 0, 1, 0, 32'h0);
    add(0, 32'h014, 1, 32'h010, 1,  0, 0, 1, 0, 32'h0);
    add(0, 32'h014, 0, 32'h000, 0,  1, 0, 1, 0, 32'h0);   // streaming
    add(1, 32'h014, 0, 32'h000, 0,  1, 1, 1, 0, 32'h0);
    add(1, 32'h018, 1, 32'h014, 1,  1, 1, 1, 0, 32'h0);
    add(1, 32'h01C, 1, 32'h018, 1,  1, 1, 1, 0, 32'h0);
    add(1, 32'h020, 1, 32'h01C, 1,  1, 1, 1, 0, 32'h0);
    add(1, 32'h024, 1, 32'h020, 1,  1, 1, 1, 1, 32'h103); // redirect with ack and pop
    add(1, 32'h100, 0, 32'h000, 0,  1, 0, 0, 0, 32'h0);
    add(1, 32'h100, 0, 32'h000, 0,  1, 1, 0, 0, 32'h0);
    add(1, 32'h104, 1, 32'h100, 1,  1, 1, 0, 0, 32'h0);
    add(1, 32'h108, 1, 32'h100, 2,  1, 0, 1, 1, 32'h200); // redirect, request unacked
    add(1, 32'h108, 0, 32'h000, 0,  1, 0, 0, 0, 32'h0);   // stale address held
    add(1, 32'h108, 0, 32'h000, 0,  1, 1, 0, 0, 32'h0);   // stale ack dropped
    add(1, 32'h200, 0, 32'h000, 0,  1, 1, 0, 0, 32'h0);
    add(1, 32'h204, 1, 32'h200, 1,  0, 0, 0, 0, 32'h0);
    add(1, 32'h204, 1, 32'h200, 1,  1, 0, 0, 1, 32'h300); // into DISCARD
    add(1, 32'h204, 0, 32'h000, 0,  1, 0, 0, 1, 32'h404); // redirect again in DISCARD
    add(1, 32'h204, 0, 32'h000, 0,  0, 1, 0, 0, 32'h0);   // stale ack, fetch_en=0 -> IDLE
    add(0, 32'h404, 0, 32'h000, 0,  1, 0, 0, 0, 32'h0);
    add(1, 32'h404, 0, 32'h000, 0,  1, 1, 0, 0, 32'h0);
    add(1, 32'h408, 1, 32'h404, 1,  1, 1, 0, 0, 32'h0);
    add(1, 32'h40C, 1, 32'h404, 2,  1, 1, 0, 0, 32'h0);
    add(1, 32'h410, 1, 32'h404, 3,  1, 0, 0, 0, 32'h0);   // leave request pending

    repeat (3) @(negedge clock);
    chk32("reset", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clock);
      chk32($sformatf("row%0d", i), tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc,
            tbl[i].e_cnt);
      drive32(tbl[i].fe, tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
    end

    // Asynchronous reset mid-request with three entries queued.
    @(negedge clock);
    chk32("pre_reset", 1'b1, 32'h410, 1'b1, 32'h404, 3'd3);
    reset = 1'b0;
    #1;
    chk32("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
    @(negedge clock);
    reset = 1'b1;
    drive32(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk32("post_reset", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);

    // Redirect low bits forced to zero and PC wrap at 2^32.
    drive32(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    @(negedge clock);
    chk32("wrap_discard", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
    drive32(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk32("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 3'd0);
    drive32(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk32("wrap_push", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 3'd1);
    drive32(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // 64-bit instance: fill from RESET_PC, then reset mid-request.
    @(negedge clock);
    check("r64 reset rd", 64'(rd64), 64'd0);
    check("r64 reset addr", addr64, Rp64);
    check("r64 reset cnt", 64'(cnt64), 64'd0);
    rst64 = 1'b1;
    fe64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("r64 req%0d rd", k), 64'(rd64), 64'd1);
      check($sformatf("r64 req%0d addr", k), addr64, Rp64 + 64'(4 * k));
      check($sformatf("r64 req%0d cnt", k), 64'(cnt64), 64'(k));
      ack64 = 1'b1;
      data64 = word(addr64);
    end
    @(negedge clock);
    ack64 = 1'b0;
    check("r64 full rd", 64'(rd64), 64'd0);
    check("r64 full cnt", 64'(cnt64), 64'd4);
    check("r64 head pc", pc64, Rp64);
    check("r64 head inst", 64'(inst64), 64'(word(Rp64)));
    rdy64 = 1'b1;
    @(negedge clock);
    rdy64 = 1'b0;
    check("r64 refill rd", 64'(rd64), 64'd1);
    check("r64 refill addr", addr64, Rp64 + 64'd16);
    rst64 = 1'b0;
    #1;
    check("r64 async rd", 64'(rd64), 64'd0);
    check("r64 async valid", 64'(valid64), 64'd0);
    check("r64 async cnt", 64'(cnt64), 64'd0);
    @(negedge clock);
    rst64 = 1'b1;
    @(negedge clock);
    check("r64 post rd", 64'(rd64), 64'd1);
    check("r64 post addr", addr64, Rp64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
